tmds_lane_gearbox: RTL and testbench

TMDS_LANE_GEARBOX -- requirements
Module: tmds_lane_gearbox

---
 rtl/tmds_lane_gearbox.sv | 93 +++++++++
 tb/tb_tmds_lane_gearbox.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_lane_gearbox.sv
// Multi-lane 10-bit TMDS word to OUT_W-bit-per-clock serializer.
// One holding register per lane feeds a shift register reloaded every SLOTS cycles.
module tmds_lane_gearbox #(
  parameter int         LANES     = 3,
  parameter int         OUT_W     = 2,
  parameter bit         LSB_FIRST = 1'b1,
  parameter logic [9:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                   ddr_bit_clock,
  input  logic                   reset,
  input  logic [LANES*10-1:0]    data,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   pattern_en,
  output logic [LANES*OUT_W-1:0] serial_out,
  output logic                   word_start,
  output logic                   underflow,
  output logic [7:0]             underflow_count
);

  localparam int SLOTS = 10 / OUT_W;
  localparam int SW    = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

  if (OUT_W != 1 && OUT_W != 2 && OUT_W != 5) begin : g_bad_out_w
    $error("tmds_lane_gearbox: OUT_W must be 1, 2 or 5");
  end

  logic [9:0]    sr [LANES];
  logic [9:0]    hr [LANES];
  logic          hold_full;
  logic [SW-1:0] slot;
  logic          load;
  logic          xfer;

  assign load       = (slot == LAST);
  assign xfer       = data_valid & ~hold_full;
  assign data_ready = ~hold_full;
  assign word_start = (slot == '0);

  always_ff @(posedge ddr_bit_clock) begin
    if (!reset) begin
      for (int n = 0; n < LANES; n++) begin
        sr[n] <= '0;
        hr[n] <= '0;
      end
      hold_full       <= 1'b0;
      slot            <= LAST;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      underflow <= 1'b0;
      slot      <= load ? '0 : slot + SW'(1);
      if (load) begin
        if (pattern_en) begin
          for (int n = 0; n < LANES; n++)
            sr[n] <= IDLE_WORD;
        end else if (hold_full) begin
          for (int n = 0; n < LANES; n++)
            sr[n] <= hr[n];
          hold_full <= 1'b0;
        end else begin
          for (int n = 0; n < LANES; n++)
            sr[n] <= IDLE_WORD;
          underflow <= 1'b1;
          if (underflow_count != 8'hFF)
            underflow_count <= underflow_count + 8'd1;
        end
      end else begin
        for (int n = 0; n < LANES; n++)
          sr[n] <= LSB_FIRST ? (sr[n] >> OUT_W)
                             : (sr[n] << OUT_W);
      end
      // Never coincides with a load from HR: that needs hold_full=1.
      if (xfer) begin
        for (int n = 0; n < LANES; n++)
          hr[n] <= data[n*10 +: 10];
        hold_full <= 1'b1;
      end
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    for (genvar k = 0; k < OUT_W; k++) begin : g_bit
      if (LSB_FIRST) begin : g_lsb
        assign serial_out[n*OUT_W+k] = sr[n][k];
      end else begin : g_msb
        assign serial_out[n*OUT_W+k] = sr[n][9-k];
      end
    end
  end

endmodule

// File: tb/tb_tmds_lane_gearbox.sv
// Bench for tmds_lane_gearbox: vector table, directed corners,
// and random traffic against a word/index reference model.
module tb_tmds_lane_gearbox;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] WA   = 10'h1E7;
  localparam logic [9:0] WB   = 10'h2D3;

  logic        clk = 1'b0;
  logic        rst_a, valid_a, pat_a, ready_a, ws_a, uf_a;
  logic [29:0] data_a;
  logic [5:0]  ser_a;
  logic [7:0]  uc_a;
  logic        rst_b, valid_b, pat_b, ready_b, ws_b, uf_b;
  logic [9:0]  data_b;
  logic [0:0]  ser_b;
  logic [7:0]  uc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_lane_gearbox #(
    .LANES(3), .OUT_W(2), .LSB_FIRST(1'b1), .IDLE_WORD(IDLE)
  ) dut_a (
    .ddr_bit_clock(clk), .reset(rst_a), .data(data_a),
    .data_valid(valid_a), .data_ready(ready_a),
    .pattern_en(pat_a), .serial_out(ser_a),
    .word_start(ws_a), .underflow(uf_a),
    .underflow_count(uc_a)
  );

  tmds_lane_gearbox #(
    .LANES(1), .OUT_W(1), .LSB_FIRST(1'b0), .IDLE_WORD(IDLE)
  ) dut_b (
    .ddr_bit_clock(clk), .reset(rst_b), .data(data_b),
    .data_valid(valid_b), .data_ready(ready_b),
    .pattern_en(pat_b), .serial_out(ser_b),
    .word_start(ws_b), .underflow(uf_b),
    .underflow_count(uc_b)
  );

  typedef struct {
    logic        rst, valid, pat;
    logic [29:0] data;
    logic [5:0]  ser;
    logic        ws, rdy, uf;
    logic [7:0]  uc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] ch(input logic [9:0] w, input int i);
    return {w[2*i+1], w[2*i]};
  endfunction

  function automatic logic [5:0] ch3(input logic [9:0] w, input int i);
    return {3{ch(w, i)}};
  endfunction

  task automatic add(input logic r, input logic v, input logic p,
                     input logic [29:0] d, input logic [5:0] s,
                     input logic w, input logic rd, input logic u,
                     input logic [7:0] c);
    vec_t x;
    x.rst = r; x.valid = v; x.pat = p; x.data = d;
    x.ser = s; x.ws = w; x.rdy = rd; x.uf = u; x.uc = c;
    vecs.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b0; valid_a = 1'b0; pat_a = 1'b0; data_a = '0;
    tick();
    rst_a = 1'b1;
  endtask

  // Leaves WA on the wire (5 chunks, now mid-word) and WB held in HR.
  task automatic prime_ab();
    reset_a();
    valid_a = 1'b1; data_a = {3{WA}};
    tick();
    valid_a = 1'b0;
    repeat (4) tick();
    valid_a = 1'b1; data_a = {3{WB}};
    tick();
    chk("prime.a0", ser_a, ch3(WA, 0));
    chk("prime.rdy1", ready_a, 1);
    tick();
    chk("prime.a1", ser_a, ch3(WA, 1));
    chk("prime.rdy0", ready_a, 0);
    valid_a = 1'b0;
  endtask

  // Reference model: current word plus chunk index, held word, counters.
  logic [9:0] m_cur [3];
  logic [9:0] m_held[3];
  logic       m_full, m_up, m_acc;
  int         m_idx, m_uc;

  task automatic model_step(input logic r, input logic v, input logic p,
                            input logic [29:0] d);
    logic x;
    m_acc = 1'b0;
    if (!r) begin
      for (int n = 0; n < 3; n++) begin
        m_cur[n] = '0; m_held[n] = '0;
      end
      m_full = 1'b0; m_up = 1'b0; m_idx = 4; m_uc = 0;
    end else begin
      x = v && !m_full;
      m_up = 1'b0;
      if (m_idx == 4) begin
        m_idx = 0;
        if (p) begin
          for (int n = 0; n < 3; n++) m_cur[n] = IDLE;
        end else if (m_full) begin
          for (int n = 0; n < 3; n++) m_cur[n] = m_held[n];
          m_full = 1'b0;
        end else begin
          for (int n = 0; n < 3; n++) m_cur[n] = IDLE;
          m_up = 1'b1;
          if (m_uc < 255) m_uc++;
        end
      end else begin
        m_idx++;
      end
      if (x) begin
        for (int n = 0; n < 3; n++) m_held[n] = d[n*10 +: 10];
        m_full = 1'b1;
        m_acc = 1'b1;
      end
    end
  endtask

  function automatic logic [5:0] model_ser();
    logic [5:0] s;
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < 2; k++)
        s[n*2+k] = m_cur[n][m_idx*2+k];
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] dd;
    int pulses;
    dd = {10'h3FF, 10'h2AA, 10'h155};
    rst_a = 1'b0; valid_a = 1'b0; pat_a = 1'b0; data_a = '0;
    rst_b = 1'b0; valid_b = 1'b0; pat_b = 1'b0; data_b = '0;

    // Reset release with no data, then continuous valid.
    add(0,0,0,'0, 6'b000000,0,1,0,0);
    add(1,0,0,'0, 6'b000000,1,1,1,1);
    repeat (3) add(1,0,0,'0, 6'b010101,0,1,0,1);
    add(1,0,0,'0, 6'b111111,0,1,0,1);
    add(1,0,0,'0, 6'b000000,1,1,1,2);
    add(1,0,0,'0, 6'b010101,0,1,0,2);
    add(0,0,0,'0, 6'b000000,0,1,0,0);
    add(1,1,0,dd, 6'b000000,1,0,1,1);
    repeat (3) add(1,1,0,dd, 6'b010101,0,0,0,1);
    add(1,1,0,dd, 6'b111111,0,0,0,1);
    repeat (3) begin
      add(1,1,0,dd, 6'b111001,1,1,0,1);
      repeat (4) add(1,1,0,dd, 6'b111001,0,0,0,1);
    end

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst; valid_a = vecs[i].valid;
      pat_a = vecs[i].pat; data_a = vecs[i].data;
      tick();
      chk($sformatf("vec%0d.ser", i), ser_a, vecs[i].ser);
      chk($sformatf("vec%0d.ws", i), ws_a, vecs[i].ws);
      chk($sformatf("vec%0d.rdy", i), ready_a, vecs[i].rdy);
      chk($sformatf("vec%0d.uf", i), uf_a, vecs[i].uf);
      chk($sformatf("vec%0d.uc", i), uc_a, vecs[i].uc);
    end

    // MSB-first, one bit per clock.
    rst_b = 1'b0;
    tick();
    chk("b.rst.ser", ser_b, 0);
    chk("b.rst.rdy", ready_b, 1);
    rst_b = 1'b1; valid_b = 1'b1; data_b = 10'h200;
    tick();
    chk("b.idle.ser", ser_b, IDLE[9]);
    chk("b.rdy0", ready_b, 0);
    valid_b = 1'b0;
    repeat (9) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("b.bit%0d", i), ser_b, (i == 0) ? 1 : 0);
      chk($sformatf("b.ws%0d", i), ws_b, (i == 0) ? 1 : 0);
    end
    tick();
    chk("b.uf", uf_b, 1);
    chk("b.uc", uc_b, 2);

    // pattern_en raised mid-word while HR holds WB.
    prime_ab();
    pat_a = 1'b1;
    for (int i = 2; i < 5; i++) begin
      tick();
      chk($sformatf("pat.a%0d", i), ser_a, ch3(WA, i));
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) pat_a = 1'b0;
      tick();
      chk($sformatf("pat.idle%0d", i), ser_a, ch3(IDLE, i));
      chk($sformatf("pat.uc%0d", i), uc_a, 1);
      chk($sformatf("pat.uf%0d", i), uf_a, 0);
      chk($sformatf("pat.rdy%0d", i), ready_a, 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("pat.b%0d", i), ser_a, ch3(WB, i));
      if (i == 0) begin
        chk("pat.b.ws", ws_a, 1);
        chk("pat.b.rdy", ready_a, 1);
      end
    end
    tick();
    chk("pat.after.uf", uf_a, 1);
    chk("pat.after.uc", uc_a, 2);

    // Reset mid-word with WB held: WB must never appear.
    prime_ab();
    rst_a = 1'b0;
    tick();
    chk("mid.rst.ser", ser_a, 0);
    chk("mid.rst.rdy", ready_a, 1);
    chk("mid.rst.ws", ws_a, 0);
    chk("mid.rst.uc", uc_a, 0);
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("mid.idle%0d", i), ser_a, ch3(IDLE, i % 5));
      chk($sformatf("mid.uf%0d", i), uf_a, (i % 5 == 0) ? 1 : 0);
    end
    chk("mid.uc", uc_a, 2);

    // Underflow counter saturation.
    reset_a();
    pulses = 0;
    for (int t = 1; t <= 1500; t++) begin
      tick();
      if (uf_a) pulses++;
      if (t == 1000) chk("sat.uc200", uc_a, 200);
    end
    chk("sat.uc", uc_a, 255);
    chk("sat.pulses", pulses, 300);

    // Random traffic against the reference model.
    rst_a = 1'b0; valid_a = 1'b0; pat_a = 1'b0;
    @(posedge clk);
    model_step(rst_a, valid_a, pat_a, data_a);
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      chk($sformatf("rnd%0d.ser", c), ser_a, model_ser());
      chk($sformatf("rnd%0d.ws", c), ws_a, (m_idx == 0) ? 1 : 0);
      chk($sformatf("rnd%0d.rdy", c), ready_a, !m_full);
      chk($sformatf("rnd%0d.uf", c), uf_a, m_up);
      chk($sformatf("rnd%0d.uc", c), uc_a, m_uc);
      rst_a = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) pat_a = ~pat_a;
      if (!valid_a || m_acc) begin
        valid_a = ($urandom_range(0, 3) != 0);
        data_a  = 30'($urandom);
      end
      @(posedge clk);
      model_step(rst_a, valid_a, pat_a, data_a);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
